// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the multi-cycle divide controller and its users:
// operand/counter widths, the controller state encodings, the EX-stage
// operation selectors that request a divide, and small sign helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    // Controller states, fixed 2-bit encodings so other blocks can decode them
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_ZERO = 2'b10,
        DIV_DONE = 2'b11
    } divState_t;

    // EX-stage ALU operation selectors that route an instruction to the divider
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;

    // Absolute value of an operand, only when it is treated as signed
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                   input logic isSigned);
        return (isSigned && value[WIDTH-1]) ? ((~value) + WIDTH'(1)) : value;
    endfunction

    // Two's-complement negation applied on demand
    function automatic logic [WIDTH-1:0] negateIf(input logic [WIDTH-1:0] value,
                                                  input logic doNegate);
        return doNegate ? ((~value) + WIDTH'(1)) : value;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_ctrl_if
// Handshake bundle between the EX stage (master) and the divide controller
// (slave).
//   start      : divide requested by the instruction in EX
//   signedDiv  : 1 = DIV (signed), 0 = DIVU
//   annul      : flush/exception, cancels any divide in flight
//   opdata1    : dividend
//   opdata2    : divisor
//   stall      : pipeline stall request from the divider
//   valid      : one-cycle pulse, result is final
//   result     : {remainder (HI), quotient (LO)}
// -----------------------------------------------------------------------------
interface div_ctrl_if;
    import div_ctrl_pkg::*;

    logic                 start;
    logic                 signedDiv;
    logic                 annul;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic                 stall;
    logic                 valid;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, signedDiv, annul, opdata1, opdata2,
        input  stall, valid, result
    );

    modport slave (
        input  start, signedDiv, annul, opdata1, opdata2,
        output stall, valid, result
    );

endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   i_rem    : partial remainder (always below the divisor magnitude)
//   i_quo    : dividend bits still to consume, quotient bits collected so far
//   i_divMag : divisor magnitude
//   o_rem    : next partial remainder
//   o_quo    : next quotient/dividend shift register
// -----------------------------------------------------------------------------
module div_step
    import div_ctrl_pkg::*;
(
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divMag,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH+1:0] w_partial;
    logic [WIDTH+1:0] w_trial;
    logic             w_trialNeg;
    logic             w_unusedTrialBit;

    // The shifted-in partial remainder can reach 2*divisor-1, which needs
    // WIDTH+1 bits once the divisor exceeds 2^(WIDTH-1); one more bit holds
    // the trial sign so large unsigned divisors are handled correctly.
    assign w_partial  = {1'b0, i_rem, i_quo[WIDTH-1]};
    assign w_trial    = w_partial - {2'b00, i_divMag};
    assign w_trialNeg = w_trial[WIDTH+1];

    // A non-negative trial always fits in WIDTH bits (it is below the divisor);
    // a negative trial restores the shifted value, which then also fits.
    assign o_rem = w_trialNeg ? w_partial[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_trialNeg};

    assign w_unusedTrialBit = w_trial[WIDTH];

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle radix-2 restoring divide controller for DIV/DIVU in EX.
// Runs 32 iterations on operand magnitudes, fixes signs at the end, and
// holds the pipeline stall while the divide is in flight.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : div_ctrl_if.slave handshake (start/signedDiv/annul/opdata1/
//           opdata2 in; stall/valid/result out)
// -----------------------------------------------------------------------------
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    div_ctrl_if.slave bus
);

    divState_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divMag;
    logic               r_negQuo;
    logic               r_negRem;
    logic               r_valid;
    logic [2*WIDTH-1:0] r_result;

    logic               w_accept;
    logic [WIDTH-1:0]   w_stepRem;
    logic [WIDTH-1:0]   w_stepQuo;

    div_step u_step (
        .i_rem    (r_rem),
        .i_quo    (r_quo),
        .i_divMag (r_divMag),
        .o_rem    (w_stepRem),
        .o_quo    (w_stepQuo)
    );

    // A request is taken only from IDLE and only when not being flushed.
    assign w_accept = (r_state == DIV_IDLE) && bus.start && !bus.annul;

    // Stall must rise in the same cycle the request appears, so the IDLE term
    // is combinational; the busy terms come straight from the state register.
    // DONE does not stall, letting the pipeline advance in the valid cycle.
    assign bus.stall  = w_accept || (r_state == DIV_BUSY) || (r_state == DIV_ZERO);
    assign bus.valid  = r_valid;
    assign bus.result = r_result;

    // Main controller: FSM, iteration counter, sign capture and the final
    // result register. The result and valid pulse are loaded on the edge that
    // enters DONE/ZERO so they are already final during that state's cycle.
    // Annul wins over everything and returns to IDLE without touching result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= DIV_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_divMag <= '0;
            r_negQuo <= 1'b0;
            r_negRem <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= 1'b0;
            if (bus.annul) begin
                r_state <= DIV_IDLE;
            end else begin
                case (r_state)
                    DIV_IDLE: begin
                        if (bus.start) begin
                            if (bus.opdata2 == '0) begin
                                r_state  <= DIV_ZERO;
                                r_result <= {bus.opdata1, {WIDTH{1'b1}}};
                                r_valid  <= 1'b1;
                            end else begin
                                r_state  <= DIV_BUSY;
                                r_cnt    <= '0;
                                r_rem    <= '0;
                                r_quo    <= magnitude(bus.opdata1, bus.signedDiv);
                                r_divMag <= magnitude(bus.opdata2, bus.signedDiv);
                                r_negQuo <= bus.signedDiv &&
                                            (bus.opdata1[WIDTH-1] != bus.opdata2[WIDTH-1]);
                                r_negRem <= bus.signedDiv && bus.opdata1[WIDTH-1];
                            end
                        end
                    end
                    DIV_BUSY: begin
                        r_rem <= w_stepRem;
                        r_quo <= w_stepQuo;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(WIDTH-1)) begin
                            r_state  <= DIV_DONE;
                            r_result <= {negateIf(w_stepRem, r_negRem),
                                         negateIf(w_stepQuo, r_negQuo)};
                            r_valid  <= 1'b1;
                        end
                    end
                    DIV_ZERO: r_state <= DIV_IDLE;
                    DIV_DONE: r_state <= DIV_IDLE;
                    default:  r_state <= DIV_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Self-checking bench for div_ctrl: directed divides with literal results,
// plus a cycle-level reference model of the stall/valid/result behaviour.
// -----------------------------------------------------------------------------
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] exSel = EXE_NOP_OP;

    int compared = 0;
    int mismatched = 0;

    div_ctrl_if bus ();

    div_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // EX-stage decode: a divide selector raises start, DIV picks signed
    assign bus.start     = (exSel == EXE_DIV_OP) || (exSel == EXE_DIVU_OP);
    assign bus.signedDiv = (exSel == EXE_DIV_OP);

    // Compare one value and report any difference
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference result from plain 64-bit integer arithmetic
    function automatic logic [63:0] modelDivide(input logic [31:0] a, input logic [31:0] b,
                                                input bit sgn);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Cycle-level model: a request accepted in cycle c completes in cycle
    // c+33 (c+1 for a zero divisor); stall covers the request cycle up to the
    // cycle before completion, plus the completion cycle for zero divisors.
    int          cycleNo = 0;
    bit          pending = 1'b0;
    int          doneCycle = 0;
    bit          doneStall = 1'b0;
    logic [63:0] pendResult = '0;
    logic [63:0] lastResult = '0;

    always @(negedge clk) begin
        logic expStall;
        logic expValid;
        cycleNo++;
        if (!rst_n) begin
            pending    = 1'b0;
            lastResult = '0;
            expStall   = 1'b0;
            expValid   = 1'b0;
        end else if (pending && cycleNo == doneCycle) begin
            expValid   = 1'b1;
            expStall   = doneStall;
            lastResult = pendResult;
            pending    = 1'b0;
        end else if (pending) begin
            expValid = 1'b0;
            expStall = 1'b1;
            if (bus.annul) pending = 1'b0;
        end else begin
            expValid = 1'b0;
            expStall = bus.start && !bus.annul;
            if (expStall) begin
                pending    = 1'b1;
                doneStall  = (bus.opdata2 == 32'd0);
                doneCycle  = cycleNo + ((bus.opdata2 == 32'd0) ? 1 : 33);
                pendResult = modelDivide(bus.opdata1, bus.opdata2, bus.signedDiv);
            end
        end
        checkOutput("model_stall", 64'(bus.stall), 64'(expStall));
        checkOutput("model_valid", 64'(bus.valid), 64'(expValid));
        checkOutput("model_result", bus.result, lastResult);
    end

    // Issue one divide, wait for valid, check latency and result literal
    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input bit sgn, input logic [63:0] expResult, input int expLatency);
        int          waited;
        bit          gotValid;
        logic [63:0] seen;
        waited   = 0;
        gotValid = 1'b0;
        seen     = '0;
        @(posedge clk);
        #1;
        bus.opdata1 = a;
        bus.opdata2 = b;
        exSel       = sgn ? EXE_DIV_OP : EXE_DIVU_OP;
        while (waited < 60 && !gotValid) begin
            @(negedge clk);
            waited++;
            if (bus.valid) begin
                gotValid = 1'b1;
                seen     = bus.result;
            end
        end
        checkOutput({name, "_valid"}, 64'(gotValid), 64'd1);
        checkOutput({name, "_latency"}, 64'(waited - 1), 64'(expLatency));
        checkOutput({name, "_result"}, seen, expResult);
        @(posedge clk);
        #1;
        exSel = EXE_NOP_OP;
    endtask

    initial begin
        int pulses;
        bus.annul   = 1'b0;
        bus.opdata1 = '0;
        bus.opdata2 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_stall", 64'(bus.stall), 64'd0);
        checkOutput("reset_valid", 64'(bus.valid), 64'd0);
        checkOutput("reset_result", bus.result, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus("divu_100_7",  32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
        applyStimulus("div_m7_2",    32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33);
        applyStimulus("divu_m7_2",   32'hFFFF_FFF9, 32'd2, 1'b0, 64'h00000001_7FFFFFFC, 33);
        applyStimulus("div_7_m2",    32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, 33);
        applyStimulus("div_zero",    32'h1234_5678, 32'd0, 1'b1, 64'h12345678_FFFFFFFF, 1);
        applyStimulus("div_ovf",     32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 33);
        applyStimulus("divu_bigdiv", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 64'h00000001_00000001, 33);

        // start together with annul in IDLE must not be accepted
        @(posedge clk);
        #1;
        bus.opdata1 = 32'd50;
        bus.opdata2 = 32'd5;
        exSel       = EXE_DIVU_OP;
        bus.annul   = 1'b1;
        @(negedge clk);
        checkOutput("annul_idle_stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        exSel     = EXE_NOP_OP;
        bus.annul = 1'b0;

        // annul in cycle N+10 of a running divide
        @(posedge clk);
        #1;
        bus.opdata1 = 32'd1000;
        bus.opdata2 = 32'd3;
        exSel       = EXE_DIVU_OP;
        repeat (10) @(posedge clk);
        #1;
        bus.annul = 1'b1;
        exSel     = EXE_NOP_OP;
        @(posedge clk);
        #1;
        bus.annul = 1'b0;
        @(negedge clk);
        checkOutput("annul_stall_after", 64'(bus.stall), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid) pulses++;
        end
        checkOutput("annul_no_valid", 64'(pulses), 64'd0);
        applyStimulus("after_annul", 32'd1000, 32'd10, 1'b0, 64'h00000000_00000064, 33);

        // reset asserted in cycle N+20 of a running divide
        @(posedge clk);
        #1;
        bus.opdata1 = 32'h1234_5678;
        bus.opdata2 = 32'd3;
        exSel       = EXE_DIVU_OP;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exSel = EXE_NOP_OP;
        #1;
        checkOutput("midrst_stall", 64'(bus.stall), 64'd0);
        checkOutput("midrst_valid", 64'(bus.valid), 64'd0);
        checkOutput("midrst_result", bus.result, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus("after_rst", 32'hFFFF_FFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Overall time bound in case the bench itself gets stuck
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, compared %0d", compared);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
